// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory request controller.
//   sq_entry_t   : one buffered store (address + data)
//   ctrl_state_e : controller FSM states
`timescale 1ns/1ps
package mem_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sq_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/store_queue.sv
// In-order store queue with youngest-match forwarding search.
// Ports:
//   clk, rst                 clock, synchronous active-high reset (pointers only)
//   push, push_addr/data     enqueue one store at the tail
//   pop                      retire the head entry
//   head_addr, head_data     oldest entry (valid when !empty)
//   full, empty              occupancy flags
//   lookup_addr              address searched for forwarding
//   hit, hit_data            youngest queued store matching lookup_addr
`timescale 1ns/1ps
module store_queue
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    sq_entry_t      entries [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  count;
    logic [IW-1:0]  idx;

    // The extra pointer bit distinguishes full from empty when the index bits match.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    assign head_addr = entries[rd_ptr[IW-1:0]].addr;
    assign head_data = entries[rd_ptr[IW-1:0]].data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is not reset: entries beyond the pointers are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr[IW-1:0]] <= '{addr: push_addr, data: push_data};
        end
    end

    // Walk from head (oldest) towards tail; later matches overwrite earlier ones,
    // so the result is the youngest matching store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[IW-1:0] + IW'(i);
            if ((PW'(i) < count) && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Initiator side of a single-port 8-bit memory. Accepts loads/stores from the
// core, buffers stores in an in-order queue, forwards queued data to loads and
// serialises all traffic onto the one memory port (one access per cycle).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_*                         core request (valid/ready handshake)
//   resp_valid/rdata/tag          load response, one cycle after acceptance
//   flush, flush_done             drain request (level) and completion pulse
//   sq_empty                      store queue is empty
//   mem_addr/data_in/enable/wr    memory port outputs (combinational)
//   mem_data_out                  memory read data (combinational)
`timescale 1ns/1ps
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int SQ_DEPTH     = 4,
    parameter int TAG_W        = 3,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [TAG_W-1:0]  resp_tag,
    input  logic              flush,
    output logic              flush_done,
    output logic              sq_empty,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_enable,
    output logic              mem_wr
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    ctrl_state_e       state_q, state_d;
    logic              flush_sent_q, flush_sent_d;
    logic [SC_W-1:0]   starve_q, starve_d;

    logic              sq_full;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    logic              force_drain;
    logic              accept_en;
    logic              req_fire;
    logic              load_fire;
    logic              store_fire;
    logic              load_miss;
    logic              drain;

    store_queue #(
        .DEPTH (SQ_DEPTH)
    ) u_sq (
        .clk         (clk),
        .rst         (rst),
        .push        (store_fire),
        .push_addr   (req_addr),
        .push_data   (req_wdata),
        .pop         (drain),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (sq_full),
        .empty       (sq_empty),
        .lookup_addr (req_addr),
        .hit         (fwd_hit),
        .hit_data    (fwd_data)
    );

    // Requests are only taken in RUN with flush low; a pending flush stops
    // new traffic in the same cycle it is raised. Reset also gates everything
    // so the memory port stays idle while rst is held.
    assign force_drain = (state_q == RUN) && !sq_empty && (starve_q == SC_W'(STARVE_LIMIT));
    assign accept_en   = !rst && (state_q == RUN) && !flush;
    assign req_ready   = accept_en && (req_is_store ? !sq_full : !force_drain);
    assign req_fire    = req_valid && req_ready;
    assign load_fire   = req_fire && !req_is_store;
    assign store_fire  = req_fire && req_is_store;
    assign load_miss   = load_fire && !fwd_hit;

    // The head drains whenever the port is free. A store pushed this cycle lands
    // at the tail, so it is never the entry being drained.
    assign drain = !rst && !sq_empty && !load_miss;

    always_comb begin
        starve_d = starve_q;
        if (drain) begin
            starve_d = '0;
        end else if (load_miss && !sq_empty) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            flush_sent_q <= 1'b0;
            starve_q     <= '0;
        end else begin
            state_q      <= state_d;
            flush_sent_q <= flush_sent_d;
            starve_q     <= starve_d;
        end
    end

    // flush_sent_q remembers that flush_done already fired while flush is held.
    always_comb begin
        state_d      = state_q;
        flush_sent_d = flush_sent_q;
        flush_done   = 1'b0;
        case (state_q)
            RUN: begin
                flush_sent_d = 1'b0;
                if (flush) state_d = FLUSH;
            end
            FLUSH: begin
                if (sq_empty && !flush_sent_q) begin
                    flush_done = !rst;
                    if (!flush) state_d = RUN;
                    else        flush_sent_d = 1'b1;
                end else if (flush_sent_q && !flush) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_tag   <= '0;
        end else begin
            resp_valid <= load_fire;
            if (load_fire) begin
                resp_rdata <= fwd_hit ? fwd_data : mem_data_out;
                resp_tag   <= req_tag;
            end
        end
    end

    // Load misses and drains are mutually exclusive by construction of drain.
    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (load_miss) begin
            mem_enable = 1'b1;
            mem_addr   = req_addr;
        end else if (drain) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = head_addr;
            mem_data_in = head_data;
        end
    end

endmodule
